// File: rtl/regfile_mp_sb.sv
// ---------------------------------------------------------------------------
// regfile_mp_sb
// Parametrised integer register file with two write ports, NUM_RD
// combinational read ports and an integrated single-bit busy scoreboard.
// The issue stage reserves a destination (sets busy) and writeback clears it.
//
// Parameters:
//   XLEN     data width of each register
//   DEPTH    number of registers (power of two, >= 2)
//   NUM_RD   number of read ports (1..4)
//   ZERO_REG 1: register 0 reads zero, ignores writes and is never busy
//
// Ports:
//   clk, reset_n            clock / asynchronous active-low reset
//   rd_addr, rd_data        packed read ports, port k at [k*AW +: AW] and
//                           [k*XLEN +: XLEN]
//   rd_busy                 busy bit of the register addressed by port k
//   wa_en/addr/data         write port A (ALU writeback)
//   wb_en/addr/data         write port B (load writeback, wins over A)
//   rsv_en, rsv_addr        reserve a destination register
//   rsv_conflict            registered pulse: reservation hit a busy register
//   busy_cnt                registered popcount of the busy vector
//
// Optional build macro:
//   REGFILE_BYPASS_EN       forward same-cycle write data/busy-clear to reads
// ---------------------------------------------------------------------------
module regfile_mp_sb #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_RD*AW-1:0]   rd_addr,
  output logic [NUM_RD*XLEN-1:0] rd_data,
  output logic [NUM_RD-1:0]      rd_busy,
  input  logic                   wa_en,
  input  logic [AW-1:0]          wa_addr,
  input  logic [XLEN-1:0]        wa_data,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [XLEN-1:0]        wb_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr,
  output logic                   rsv_conflict,
  output logic [AW:0]            busy_cnt
);

  logic [XLEN-1:0]  regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic             wa_ok;
  logic             wb_ok;
  logic             rsv_ok;
  logic             conflict_nxt;
  logic [AW:0]      cnt_nxt;

  // Requests aimed at a hardwired register 0 are dropped up front, so
  // nothing downstream needs to special-case address 0.
  assign wa_ok  = wa_en  && !((ZERO_REG != 0) && (wa_addr  == '0));
  assign wb_ok  = wb_en  && !((ZERO_REG != 0) && (wb_addr  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Next scoreboard state: writes clear first, then the reservation sets,
  // so a reserve to a register being written leaves it busy for the new
  // owner. A conflict is only flagged when the busy bit is not being cleared
  // this cycle. busy_cnt is the popcount of the next vector, so it stays
  // consistent with simultaneous set and clears.
  always_comb begin
    busy_nxt = busy;
    if (wa_ok) busy_nxt[wa_addr] = 1'b0;
    if (wb_ok) busy_nxt[wb_addr] = 1'b0;
    if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    conflict_nxt = rsv_ok && busy[rsv_addr]
                   && !(wa_ok && (wa_addr == rsv_addr))
                   && !(wb_ok && (wb_addr == rsv_addr));
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[i]);
    end
  end

  // Scoreboard and its registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy         <= '0;
      rsv_conflict <= 1'b0;
      busy_cnt     <= '0;
    end else begin
      busy         <= busy_nxt;
      rsv_conflict <= conflict_nxt;
      busy_cnt     <= cnt_nxt;
    end
  end

  // Register array; port B is written last so it wins on an address clash.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (wa_ok) regs[wa_addr] <= wa_data;
      if (wb_ok) regs[wb_addr] <= wb_data;
    end
  end

  // Combinational read ports.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign addr = rd_addr[k*AW +: AW];

`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle writes (wb over wa over array). A forwarded write
    // also hides the busy bit unless a reservation re-targets the register.
    always_comb begin
      data = regs[addr];
      bsy  = busy[addr];
      if (wb_ok && (wb_addr == addr)) begin
        data = wb_data;
      end else if (wa_ok && (wa_addr == addr)) begin
        data = wa_data;
      end
      if (((wb_ok && (wb_addr == addr)) || (wa_ok && (wa_addr == addr)))
          && !(rsv_ok && (rsv_addr == addr))) begin
        bsy = 1'b0;
      end
    end
`else
    assign data = regs[addr];
    assign bsy  = busy[addr];
`endif

    assign rd_data[k*XLEN +: XLEN] = data;
    assign rd_busy[k]              = bsy;
  end

endmodule
